vga_timing: RTL

Free-running 800x600@60 Hz VGA raster generator that produces the pixel coordinates, sync pulses and blanking flags consumed by `game_ctl` (first stage: `draw_background`). It runs on the 40 MHz pixel clock. All outputs are registered and mutually aligned, so every downstream stage sees one consistent pixel per cycle. It also emits a one-cycle frame-start strobe and a frame counter for game-logic pacing.

---
 rtl/vga_timing_if.sv | 19 +
 rtl/vga_timing.sv | 91 +++++++++
 2 files changed

// File: rtl/vga_timing_if.sv
// rtl/vga_timing_if.sv - raster output bundle from vga_timing to downstream pixel stages
interface vga_timing_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt
    );

    modport slave (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - free-running 800x600@60 raster generator with frame strobe/counter
// Optional VGA_SYNC_NEG_EN: active-low hsync/vsync (inactive and reset level 1).
module vga_timing #(
    parameter int H_VIS  = 800,
    parameter int H_FP   = 40,
    parameter int H_SYNC = 128,
    parameter int H_BP   = 88,
    parameter int V_VIS  = 600,
    parameter int V_FP   = 1,
    parameter int V_SYNC = 4,
    parameter int V_BP   = 23
) (
    input  logic         pclk,
    input  logic         rst,
    vga_timing_if.master vga
);
    localparam logic [10:0] H_TOT  = 11'(H_VIS + H_FP + H_SYNC + H_BP);
    localparam logic [10:0] V_TOT  = 11'(V_VIS + V_FP + V_SYNC + V_BP);
    localparam logic [10:0] H_VISL = 11'(H_VIS);
    localparam logic [10:0] V_VISL = 11'(V_VIS);
    localparam logic [10:0] HS_BEG = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END = 11'(V_VIS + V_FP + V_SYNC);

`ifdef VGA_SYNC_NEG_EN
    localparam logic SYNC_ON = 1'b0;
`else
    localparam logic SYNC_ON = 1'b1;
`endif

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        frame_start_q, frame_start_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        h_wrap;
    logic        v_last;

    // Flags are derived from the next counter values so they line up with the
    // registered coordinates in the same cycle.
    always_comb begin
        h_wrap        = (hcount_q == H_TOT - 11'd1);
        v_last        = (vcount_q == V_TOT - 11'd1);
        hcount_d      = h_wrap ? 11'd0 : hcount_q + 11'd1;
        vcount_d      = vcount_q;
        if (h_wrap) begin
            vcount_d = v_last ? 11'd0 : vcount_q + 11'd1;
        end
        hblnk_d       = (hcount_d >= H_VISL);
        vblnk_d       = (vcount_d >= V_VISL);
        hsync_d       = (hcount_d >= HS_BEG && hcount_d < HS_END) ? SYNC_ON : ~SYNC_ON;
        vsync_d       = (vcount_d >= VS_BEG && vcount_d < VS_END) ? SYNC_ON : ~SYNC_ON;
        frame_start_d = h_wrap && v_last;
        frame_cnt_d   = frame_cnt_q + {7'd0, frame_start_d};
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hcount_q      <= 11'd0;
            vcount_q      <= 11'd0;
            hsync_q       <= ~SYNC_ON;
            vsync_q       <= ~SYNC_ON;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign vga.hcount      = hcount_q;
    assign vga.vcount      = vcount_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.hblnk       = hblnk_q;
    assign vga.vblnk       = vblnk_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_cnt   = frame_cnt_q;
endmodule
